// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV core types and constants
// Holds the IF/ID register layout, reset/NOP constants and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN_BITS       = 32;
  localparam int IMEM_WORD_BYTES = 4;

  localparam logic [XLEN_BITS-1:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0]          NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_BITS-1:0] pc;
    logic [31:0]          instruction;
    logic [XLEN_BITS-1:0] pc_plus4;
    logic                 valid_if_id;
  } if_id_reg_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN_BITS-1:0] next_word_addr(input logic [XLEN_BITS-1:0] addr);
    return addr + XLEN_BITS'(IMEM_WORD_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage, one outstanding imem request
// Optional IF_MISALIGN_CHECK_EN adds misalign_o and a HALT state on unaligned redirects.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                XLEN       = XLEN_BITS,
  parameter logic [XLEN-1:0]   RESET_ADDR = RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output if_id_reg_t      fetch_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_reg_t      out_q, out_d;
  logic            stale_q, stale_d;
  logic            req_accept;
  logic            in_flight_next;

`ifdef IF_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
  assign misalign_o = misalign_q;
`endif

  // Request is suppressed during the reset cycle even if state_q still reads REQ.
  assign imem_req_valid_o = (state_q == REQ) && !reset;
  assign imem_req_addr_o  = pc_q;
  assign req_accept       = imem_req_valid_o && imem_req_ready_i;
  assign fetch_o          = out_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_d          = out_q;
    stale_d        = stale_q;
    in_flight_next = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    misalign_d     = misalign_q;
`endif

    case (state_q)
      REQ: begin
        if (req_accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = REQ;
          end else begin
            out_d.pc          = pc_q;
            out_d.instruction = imem_rsp_data_i;
            out_d.pc_plus4    = next_word_addr(pc_q);
            out_d.valid_if_id = 1'b1;
            pc_d              = next_word_addr(pc_q);
            state_d           = FULL;
          end
        end
      end
      FULL: begin
        if (out_q.valid_if_id && !stall_i) begin
          out_d.valid_if_id = 1'b0;
          state_d           = REQ;
        end
      end
      HALT: begin
        // A request issued before halting may still answer; swallow it here.
        if (imem_rsp_valid_i) begin
          stale_d = 1'b0;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase

    if (redirect_valid_i) begin
      in_flight_next = ((state_q == REQ)  && req_accept) ||
                       ((state_q == WAIT) && !imem_rsp_valid_i) ||
                       ((state_q == HALT) && stale_q && !imem_rsp_valid_i);
      pc_d              = redirect_pc_i;
      out_d.valid_if_id = 1'b0;
      stale_d           = in_flight_next;
      state_d           = in_flight_next ? WAIT : REQ;
`ifdef IF_MISALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= REQ;
      pc_q              <= RESET_ADDR;
      out_q.pc          <= RESET_ADDR;
      out_q.instruction <= NOP_INSTR;
      out_q.pc_plus4    <= next_word_addr(RESET_ADDR);
      out_q.valid_if_id <= 1'b0;
      stale_q           <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      stale_q <= stale_d;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
// Memory responder answers each accepted request with ~addr after a programmable latency.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  if_id_reg_t  fetch_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  if_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .fetch_o          (fetch_o)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .misalign_o       (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          lat;
  int          cnt;
  int          n_accept;
  bit          pend;
  logic [31:0] pend_addr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic if_id_reg_t exp_fetch(input logic [31:0] pc);
    if_id_reg_t e;
    e.pc          = pc;
    e.instruction = ~pc;
    e.pc_plus4    = pc + 32'd4;
    e.valid_if_id = 1'b1;
    return e;
  endfunction

  function automatic if_id_reg_t exp_reset();
    if_id_reg_t e;
    e.pc          = 32'h0000_1000;
    e.instruction = 32'h0000_0013;
    e.pc_plus4    = 32'h0000_1004;
    e.valid_if_id = 1'b0;
    return e;
  endfunction

  // One clock: note acceptance, advance the memory model, drive the response for the next edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid_o && imem_req_ready_i;
    a   = imem_req_addr_o;
    @(posedge clk);
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt <= 1) pend = 1'b0;
        else cnt--;
      end
      if (acc) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = a;
        n_accept++;
      end
    end
    @(negedge clk);
    imem_rsp_valid_i = pend && (cnt == 1);
    imem_rsp_data_i  = imem_rsp_valid_i ? ~pend_addr : 32'h0;
  endtask

  task automatic wait_fetch(input string tag);
    int k;
    k = 0;
    #1;
    while (!fetch_o.valid_if_id && k < 20) begin
      tick();
      #1;
      k++;
    end
    check(tag, fetch_o.valid_if_id, 1'b1);
  endtask

  // Waits for the next request while recording whether any instruction surfaced meanwhile.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int k;
    bit seen;
    k    = 0;
    seen = 0;
    #1;
    while (!imem_req_valid_o && k < 20) begin
      if (fetch_o.valid_if_id) seen = 1;
      tick();
      #1;
      k++;
    end
    check({tag, "_timeout"}, imem_req_valid_o, 1'b1);
    check({tag, "_no_stale"}, seen, 1'b0);
    check({tag, "_addr"}, imem_req_addr_o, exp_addr);
  endtask

  initial begin
    int acc0;
    int k;
    n_checks = 0;
    n_fail   = 0;
    n_accept = 0;
    pend     = 1'b0;
    cnt      = 0;
    lat      = 1;
    reset            = 1'b1;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;

    @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid_o, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_fetch", fetch_o, exp_reset());
    check("rst_req", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_1000});

    // Latency 1, ready always: three instructions, one every third cycle.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("seq_req", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_1000 + 32'(4 * i)});
      tick();
      #1;
      check("seq_wait", {imem_req_valid_o, fetch_o.valid_if_id}, 2'b00);
      tick();
      #1;
      check("seq_fetch", fetch_o, exp_fetch(32'h0000_1000 + 32'(4 * i)));
      tick();
    end

    // Stall held five cycles in FULL.
    tick();
    tick();
    stall_i = 1'b1;
    #1;
    check("stall_first", fetch_o, exp_fetch(32'h0000_100C));
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("stall_hold", {imem_req_valid_o, fetch_o}, {1'b0, exp_fetch(32'h0000_100C)});
    end
    stall_i = 1'b0;
    tick();
    #1;
    check("stall_release", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_1010});

    // Redirect while waiting, latency 3.
    lat = 3;
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0100;
    tick();
    redirect_valid_i = 1'b0;
    wait_req("redir_wait", 32'h0000_0100);
    lat = 1;
    wait_fetch("redir_fetch_to");
    check("redir_fetch", fetch_o, exp_fetch(32'h0000_0100));
    tick();

    // Redirect in the same cycle as the response.
    lat = 2;
    #1;
    check("same_req", imem_req_addr_o, 32'h0000_0104);
    tick();
    k = 0;
    while (!imem_rsp_valid_i && k < 10) begin
      tick();
      k++;
    end
    check("same_rsp_seen", imem_rsp_valid_i, 1'b1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0200;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check("same_next", {imem_req_valid_o, imem_req_addr_o, fetch_o.valid_if_id}, {1'b1, 32'h0000_0200, 1'b0});

    // Memory not ready for four cycles.
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("nrdy_hold", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_0200});
      tick();
    end
    acc0 = n_accept;
    imem_req_ready_i = 1'b1;
    tick();
    #1;
    check("nrdy_once", 32'(n_accept - acc0), 32'd1);
    check("nrdy_wait", imem_req_valid_o, 1'b0);
    wait_fetch("nrdy_fetch_to");
    check("nrdy_fetch", fetch_o, exp_fetch(32'h0000_0200));
    check("nrdy_once_after", 32'(n_accept - acc0), 32'd1);
    tick();

    // Address wrap at the top of the space.
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    #1;
    check("wrap_req", imem_req_addr_o, 32'hFFFF_FFFC);
    wait_fetch("wrap_fetch_to");
    check("wrap_fetch", fetch_o, exp_fetch(32'hFFFF_FFFC));
    check("wrap_plus4", fetch_o.pc_plus4, 32'h0000_0000);
    tick();
    #1;
    check("wrap_next", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_0000});

    // Redirect in the cycle the request is accepted: that response is stale.
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0300;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check("acc_redir_wait", imem_req_valid_o, 1'b0);
    wait_req("acc_redir", 32'h0000_0300);

    // Reset in the middle of a transaction.
    lat = 3;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_req", imem_req_valid_o, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_fetch", fetch_o, exp_reset());
    check("mid_rst_req2", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_1000});
    wait_fetch("mid_rst_fetch_to");
    check("mid_rst_first", fetch_o, exp_fetch(32'h0000_1000));
    tick();

`ifdef IF_MISALIGN_CHECK_EN
    check("mis_init", misalign_o, 1'b0);
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0102;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mis_halt", {misalign_o, imem_req_valid_o, fetch_o.valid_if_id}, 3'b100);
      tick();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0400;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check("mis_resume", {imem_req_valid_o, imem_req_addr_o}, {1'b1, 32'h0000_0400});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
